// File: rtl/reset_sequencer.sv
// Staged reset release: hold all channels, then release them one by one every GAP_CYC cycles.
// Optional watchdog restart is compiled in when RST_WATCHDOG_EN is defined.
module reset_sequencer #(
  parameter int unsigned NCH      = 3,
  parameter int unsigned HOLD_CYC = 255,
  parameter int unsigned GAP_CYC  = 16,
  parameter int unsigned WDT_CYC  = 65535,
  parameter int unsigned CW       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sw_rst_req,
  input  logic           wdt_kick,
  output logic [NCH-1:0] rst_n_out,
  output logic           seq_done,
  output logic [1:0]     rst_cause
);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  state_t         state;
  logic           sync1;
  logic           sync2;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] rel_next;
  logic           restart;
  logic [1:0]     restart_cause;

  // Next release pattern: shift the released mask up by one channel.
  always_comb begin
    rel_next    = rst_n_out << 1;
    rel_next[0] = 1'b1;
  end

`ifdef RST_WATCHDOG_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYC - 1);

  logic [CW-1:0] wdt_cnt;
  logic          wdt_expire;

  // Expiry fires on the edge at which the count would reach WDT_CYC.
  assign wdt_expire = (state == RUN) && !wdt_kick && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if (state != RUN || sw_rst_req || wdt_kick || wdt_expire) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != '1) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end

  // Soft reset takes priority over a simultaneous watchdog expiry.
  always_comb begin
    restart       = sw_rst_req || wdt_expire;
    restart_cause = sw_rst_req ? 2'b01 : 2'b10;
  end
`else
  logic unused_wdt;

  assign unused_wdt = &{1'b0, wdt_kick, WDT_CYC[0]};

  always_comb begin
    restart       = sw_rst_req;
    restart_cause = 2'b01;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= HOLD;
      cnt       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
      rst_cause <= 2'b00;
    end else begin
      sync1 <= 1'b1;
      sync2 <= sync1;
      if (restart) begin
        state     <= HOLD;
        cnt       <= '0;
        rst_n_out <= '0;
        seq_done  <= 1'b0;
        rst_cause <= restart_cause;
      end else begin
        case (state)
          HOLD: begin
            if (sync2) begin
              if (cnt == HOLD_LAST) begin
                cnt       <= '0;
                rst_n_out <= rel_next;
                if (NCH == 1) begin
                  state    <= RUN;
                  seq_done <= 1'b1;
                end else begin
                  state <= REL;
                end
              end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          REL: begin
            if (cnt == GAP_LAST) begin
              cnt       <= '0;
              rst_n_out <= rel_next;
              if (&rel_next) begin
                state    <= RUN;
                seq_done <= 1'b1;
              end
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            cnt <= '0;
          end
          default: begin
            state <= HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed power-up/soft/async/watchdog scenarios plus random traffic,
// checked every cycle against a release-time model (bit k is up once t >= HOLD + k*GAP).
module tb_reset_sequencer;

  localparam int NCH  = 3;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int WDT  = 32;
  localparam int FULL = HOLD + (NCH - 1) * GAP;

  logic           clk;
  logic           rst_n;
  logic           sw_rst_req;
  logic           wdt_kick;
  logic [NCH-1:0] rst_n_out;
  logic           seq_done;
  logic [1:0]     rst_cause;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer #(
    .NCH(NCH), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .WDT_CYC(WDT), .CW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .rst_cause(rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: sync = edges seen since reset release (caps at 2), t = counted edges since sequence start,
  // wd = unkicked edges spent fully released.
  typedef struct {
    int         sync;
    int         t;
    int         wd;
    logic [1:0] cause;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, logic sw, logic kick);
    mstate_t n = s;
    bit running = (s.sync >= 2) && (s.t >= FULL);
    if (s.sync < 2) n.sync = s.sync + 1;
    if (sw) begin
      n.t = 0; n.cause = 2'b01; n.wd = 0;
    end else if (running) begin
`ifdef RST_WATCHDOG_EN
      if (kick) n.wd = 0;
      else if (s.wd + 1 >= WDT) begin
        n.t = 0; n.cause = 2'b10; n.wd = 0;
      end else n.wd = s.wd + 1;
`else
      if (kick) n.wd = 0;
`endif
    end else if (s.sync >= 2) begin
      n.t = (s.t < 1000000) ? s.t + 1 : s.t;
    end
    return n;
  endfunction

  function automatic logic [NCH-1:0] exp_out(int t);
    logic [NCH-1:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k] = (t >= HOLD + k * GAP);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{sync: 0, t: 0, wd: 0, cause: 2'b00};
    else        m <= model_step(m, sw_rst_req, wdt_kick);
  end

  always @(negedge clk) begin
    n_cmp++;
    if (rst_n_out !== exp_out(m.t) || seq_done !== (m.t >= FULL) || rst_cause !== m.cause) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t got out=%b done=%b cause=%b exp out=%b done=%b cause=%b",
               $time, rst_n_out, seq_done, rst_cause, exp_out(m.t), (m.t >= FULL), m.cause);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assumes rst_n was just released between edges; edge numbering starts at the first edge after it.
  task automatic power_up_check(input string tag);
    for (int e = 1; e <= 18; e++) begin
      tick(1);
      case (e)
        9:  chk({tag, "_e9"},  32'(rst_n_out), 32'b000);
        10: chk({tag, "_e10"}, 32'(rst_n_out), 32'b001);
        13: chk({tag, "_e13"}, 32'(rst_n_out), 32'b001);
        14: chk({tag, "_e14"}, 32'(rst_n_out), 32'b011);
        17: chk({tag, "_e17"}, 32'({seq_done, rst_n_out}), 32'b0011);
        18: begin
          chk({tag, "_e18"}, 32'({seq_done, rst_n_out}), 32'b1111);
          chk({tag, "_cause"}, 32'(rst_cause), 32'b00);
        end
        default: ;
      endcase
    end
  endtask

  task automatic soft_pulse;
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0;
    tick(3);
    chk("reset_state", 32'({rst_cause, seq_done, rst_n_out}), 32'b0);
    #4 rst_n = 1'b1;
    power_up_check("pwrup");

    // Soft reset from RUN
    soft_pulse();
    chk("soft_drop", 32'({rst_cause, seq_done, rst_n_out}), 32'b010000);
    tick(7);  chk("soft_e7",  32'(rst_n_out), 32'b000);
    tick(1);  chk("soft_e8",  32'(rst_n_out), 32'b001);
    tick(8);  chk("soft_e16", 32'({rst_cause, seq_done, rst_n_out}), 32'b011111);

    // Restart in the middle of the release phase
    soft_pulse();
    tick(12); chk("mid_011", 32'(rst_n_out), 32'b011);
    soft_pulse();
    chk("mid_drop", 32'(rst_n_out), 32'b000);
    tick(7);  chk("mid_e7",  32'(rst_n_out), 32'b000);
    tick(1);  chk("mid_e8",  32'(rst_n_out), 32'b001);
    tick(4);  chk("mid_e12", 32'(rst_n_out), 32'b011);
    tick(4);  chk("mid_e16", 32'({seq_done, rst_n_out}), 32'b1111);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1 chk("async_drop", 32'({rst_cause, seq_done, rst_n_out}), 32'b0);
    tick(2);
    #2 rst_n = 1'b1;
    power_up_check("async");

`ifdef RST_WATCHDOG_EN
    tick(31); chk("wdt_pre",  32'({rst_cause, seq_done, rst_n_out}), 32'b001111);
    tick(1);  chk("wdt_fire", 32'({rst_cause, seq_done, rst_n_out}), 32'b100000);
    tick(16); chk("wdt_rerun", 32'({seq_done, rst_n_out}), 32'b1111);
    for (int i = 1; i <= 100; i++) begin
      wdt_kick = (i % 20 == 0);
      tick(1);
    end
    wdt_kick = 1'b0;
    chk("wdt_kicked", 32'({rst_cause, seq_done, rst_n_out}), 32'b101111);
    tick(31); chk("coll_pre", 32'({seq_done, rst_n_out}), 32'b1111);
    soft_pulse();
    chk("coll_cause", 32'({rst_cause, seq_done, rst_n_out}), 32'b010000);
    tick(16);
`else
    tick(100);
    chk("nowdt_hold", 32'({rst_cause, seq_done, rst_n_out}), 32'b001111);
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      sw_rst_req = ($urandom_range(0, 63) == 0);
      wdt_kick   = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        tick($urandom_range(0, 3));
        #2 rst_n = 1'b1;
      end
      tick(1);
    end
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
